// File: rtl/tmds_period_scheduler_pkg.sv
// Shared TMDS symbols for the period scheduler: control tokens, guard-band
// words and the period_state encoding.
package tmds_period_scheduler_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_WORD_0 = 10'b1011001100;
  localparam logic [9:0] GUARD_WORD_1 = 10'b0100110011;
  localparam logic [9:0] GUARD_WORD_2 = 10'b1011001100;

  typedef enum logic [1:0] {
    PERIOD_CTRL     = 2'd0,
    PERIOD_PREAMBLE = 2'd1,
    PERIOD_GUARD    = 2'd2,
    PERIOD_VIDEO    = 2'd3
  } period_e;

  // Index is {c1, c0}, i.e. {vsync, hsync} on channel 0.
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_period_scheduler_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
module tmds_delay_line #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/tmds_period_scheduler.sv
// Schedules TMDS control / preamble / guard / video periods in front of a
// delayed video stream so the preamble and guard band precede each line.
module tmds_period_scheduler
  import tmds_period_scheduler_pkg::*;
#(
  parameter int HDMI_MODE    = 1,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       video_de,
  input  logic       video_hsync,
  input  logic       video_vsync,
  input  logic [9:0] tmds_word_0,
  input  logic [9:0] tmds_word_1,
  input  logic [9:0] tmds_word_2,
  output logic [9:0] chan_word_0,
  output logic [9:0] chan_word_1,
  output logic [9:0] chan_word_2,
  output logic [1:0] period_state,
  output logic       de_out,
  output logic       sched_err
);

  localparam int LAT = PREAMBLE_LEN + GUARD_LEN;
  localparam int DW  = 33;
  localparam logic [3:0] PRE_LAST   = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_LEN - 1);

  logic [DW-1:0] dl_in, dl_out;
  logic          dl_de, dl_hs, dl_vs;
  logic [9:0]    dl_w0, dl_w1, dl_w2;

  period_e    state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic       de_prev_q, de_out_q, de_out_d, err_q, err_d, de_rise;
  logic [9:0] chan0_q, chan0_d, chan1_q, chan1_d, chan2_q, chan2_d;

  assign dl_in = {video_de, video_hsync, video_vsync, tmds_word_0, tmds_word_1, tmds_word_2};
  assign {dl_de, dl_hs, dl_vs, dl_w0, dl_w1, dl_w2} = dl_out;

  tmds_delay_line #(.WIDTH(DW), .DEPTH(LAT)) u_delay (
    .clk   (pixel_clk),
    .rst_n (rst_n),
    .din   (dl_in),
    .dout  (dl_out)
  );

  assign de_rise = video_de & ~de_prev_q;

  // The output register is the final pipeline stage, so the mux follows
  // state_d to keep chan_word_* aligned with period_state.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    err_d    = err_q;
    de_out_d = dl_de;
    case (state_q)
      PERIOD_CTRL: begin
        if (dl_de) begin
          state_d = PERIOD_VIDEO;
        end else if (HDMI_MODE != 0 && de_rise) begin
          state_d = PERIOD_PREAMBLE;
          phase_d = PRE_LAST;
        end
      end
      PERIOD_PREAMBLE: begin
        if (phase_q == 4'd0) begin
          state_d = PERIOD_GUARD;
          phase_d = GUARD_LAST;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      PERIOD_GUARD: begin
        if (phase_q == 4'd0) begin
          state_d = PERIOD_VIDEO;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      default: begin
        if (!dl_de) begin
          state_d = PERIOD_CTRL;
        end
      end
    endcase

    // A line whose DE rises while the scheduler is busy gets no preamble.
    if (HDMI_MODE != 0 && de_rise && (state_q != PERIOD_CTRL || dl_de)) begin
      err_d = 1'b1;
    end

    chan0_d = ctrl_token({dl_vs, dl_hs});
    chan1_d = CTRL_TOKEN_00;
    chan2_d = CTRL_TOKEN_00;
    case (state_d)
      PERIOD_PREAMBLE: chan1_d = CTRL_TOKEN_01;
      PERIOD_GUARD: begin
        chan0_d = GUARD_WORD_0;
        chan1_d = GUARD_WORD_1;
        chan2_d = GUARD_WORD_2;
      end
      PERIOD_VIDEO: begin
        chan0_d = dl_w0;
        chan1_d = dl_w1;
        chan2_d = dl_w2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PERIOD_CTRL;
      phase_q   <= 4'd0;
      de_prev_q <= 1'b0;
      de_out_q  <= 1'b0;
      err_q     <= 1'b0;
      chan0_q   <= CTRL_TOKEN_00;
      chan1_q   <= CTRL_TOKEN_00;
      chan2_q   <= CTRL_TOKEN_00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      de_prev_q <= video_de;
      de_out_q  <= de_out_d;
      err_q     <= err_d;
      chan0_q   <= chan0_d;
      chan1_q   <= chan1_d;
      chan2_q   <= chan2_d;
    end
  end

  assign chan_word_0  = chan0_q;
  assign chan_word_1  = chan1_q;
  assign chan_word_2  = chan2_q;
  assign period_state = state_q;
  assign de_out       = de_out_q;
  assign sched_err    = err_q;

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// Directed bench: one HDMI-mode and one DVI-mode scheduler share stimulus;
// r counts clock edges from the first DE sample of each scenario.
module tb_tmds_period_scheduler;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] G0  = 10'b1011001100;
  localparam logic [9:0] G1  = 10'b0100110011;
  localparam logic [9:0] G2  = 10'b1011001100;
  localparam logic [1:0] S_CTRL = 2'd0, S_PRE = 2'd1, S_GUARD = 2'd2, S_VIDEO = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n, de, hs, vs;
  logic [9:0] w0, w1, w2;
  logic [9:0] h_c0, h_c1, h_c2, d_c0, d_c1, d_c2;
  logic [1:0] h_st, d_st;
  logic       h_de, h_err, d_de, d_err;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  tmds_period_scheduler #(.HDMI_MODE(1), .PREAMBLE_LEN(8), .GUARD_LEN(2)) dut_hdmi (
    .pixel_clk(clk), .rst_n(rst_n), .video_de(de), .video_hsync(hs), .video_vsync(vs),
    .tmds_word_0(w0), .tmds_word_1(w1), .tmds_word_2(w2),
    .chan_word_0(h_c0), .chan_word_1(h_c1), .chan_word_2(h_c2),
    .period_state(h_st), .de_out(h_de), .sched_err(h_err)
  );

  tmds_period_scheduler #(.HDMI_MODE(0), .PREAMBLE_LEN(8), .GUARD_LEN(2)) dut_dvi (
    .pixel_clk(clk), .rst_n(rst_n), .video_de(de), .video_hsync(hs), .video_vsync(vs),
    .tmds_word_0(w0), .tmds_word_1(w1), .tmds_word_2(w2),
    .chan_word_0(d_c0), .chan_word_1(d_c1), .chan_word_2(d_c2),
    .period_state(d_st), .de_out(d_de), .sched_err(d_err)
  );

  function automatic logic [9:0] wa(input int r); return 10'(32'h200 + r); endfunction
  function automatic logic [9:0] wb(input int r); return 10'(32'h0a5 + 7 * r); endfunction
  function automatic logic [9:0] wc(input int r); return 10'(32'h3f0 - 3 * r); endfunction

  // Drive the sample taken at edge r, then move to just after that edge.
  task automatic tick(input logic de_v, input int r);
    de = de_v;
    w0 = wa(r);
    w1 = wb(r);
    w2 = wc(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 100 + i);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; de = 1'b0; hs = 1'b1; vs = 1'b0;
    w0 = '0; w1 = '0; w2 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(12);
    n_checks++;
    if ({h_c0, h_c1, h_c2} !== {T01, T00, T00}) begin
      n_fail++; $display("FAIL idle_hsync_words got %h %h %h exp %h %h %h", h_c0, h_c1, h_c2, T01, T00, T00);
    end
    n_checks++;
    if (h_st !== S_CTRL || d_st !== S_CTRL) begin
      n_fail++; $display("FAIL idle_state got %0d/%0d exp 0", h_st, d_st);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({h_c0, h_c1, h_c2, d_c0} !== {T00, T00, T00, T00}) begin
      n_fail++; $display("FAIL async_reset_words got %h %h %h %h exp all %h", h_c0, h_c1, h_c2, d_c0, T00);
    end
    n_checks++;
    if ({h_st, h_de, h_err, d_st, d_de, d_err} !== 8'h00) begin
      n_fail++; $display("FAIL async_reset_ctrl got %b exp 00000000", {h_st, h_de, h_err, d_st, d_de, d_err});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    hs = 1'b0; vs = 1'b1;
    idle(12);
  endtask

  task automatic test_hdmi_line;
    logic [1:0]  eh, ed;
    logic [29:0] ech, ecd;
    idle(12);
    for (int r = 0; r < 16; r++) begin
      tick(r < 4, r);
      eh = (r < 8) ? S_PRE : (r < 10) ? S_GUARD : (r < 14) ? S_VIDEO : S_CTRL;
      ed = (r >= 10 && r < 14) ? S_VIDEO : S_CTRL;
      case (eh)
        S_PRE:   ech = {T10, T01, T00};
        S_GUARD: ech = {G0, G1, G2};
        S_VIDEO: ech = {wa(r - 10), wb(r - 10), wc(r - 10)};
        default: ech = {T10, T00, T00};
      endcase
      ecd = (ed == S_VIDEO) ? {wa(r - 10), wb(r - 10), wc(r - 10)} : {T10, T00, T00};
      n_checks++;
      if (h_st !== eh) begin n_fail++; $display("FAIL hdmi_state r=%0d got %0d exp %0d", r, h_st, eh); end
      n_checks++;
      if ({h_c0, h_c1, h_c2} !== ech) begin
        n_fail++; $display("FAIL hdmi_words r=%0d got %h exp %h", r, {h_c0, h_c1, h_c2}, ech);
      end
      n_checks++;
      if (d_st !== ed) begin n_fail++; $display("FAIL dvi_state r=%0d got %0d exp %0d", r, d_st, ed); end
      n_checks++;
      if ({d_c0, d_c1, d_c2} !== ecd) begin
        n_fail++; $display("FAIL dvi_words r=%0d got %h exp %h", r, {d_c0, d_c1, d_c2}, ecd);
      end
      n_checks++;
      if (h_de !== (ed == S_VIDEO) || d_de !== (ed == S_VIDEO) || h_err !== 1'b0) begin
        n_fail++; $display("FAIL line_de_err r=%0d got %b%b%b exp %b%b0", r, h_de, d_de, h_err, ed == S_VIDEO, ed == S_VIDEO);
      end
    end
  endtask

  task automatic test_single_pulse;
    logic [1:0] eh;
    idle(12);
    for (int r = 0; r < 13; r++) begin
      tick(r == 0, r);
      eh = (r < 8) ? S_PRE : (r < 10) ? S_GUARD : (r == 10) ? S_VIDEO : S_CTRL;
      n_checks++;
      if (h_st !== eh || h_de !== (r == 10)) begin
        n_fail++; $display("FAIL pulse_state r=%0d got %0d/%b exp %0d/%b", r, h_st, h_de, eh, r == 10);
      end
    end
    n_checks++;
    if (h_err !== 1'b0) begin n_fail++; $display("FAIL pulse_err got %b exp 0", h_err); end
  endtask

  task automatic test_midline_reset;
    logic [1:0] eh;
    idle(12);
    for (int r = 0; r < 5; r++) tick(r < 4, r);
    n_checks++;
    if (h_st !== S_PRE || h_c1 !== T01) begin
      n_fail++; $display("FAIL pre_reset_state got %0d %h exp 1 %h", h_st, h_c1, T01);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (h_st !== S_CTRL || h_c1 !== T00 || h_c0 !== T00 || h_de !== 1'b0) begin
      n_fail++; $display("FAIL midline_reset got %0d %h %h %b exp 0 %h %h 0", h_st, h_c0, h_c1, h_de, T00, T00);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int r = 5; r < 19; r++) begin
      tick(1'b0, r);
      n_checks++;
      if (h_st !== S_CTRL || h_de !== 1'b0) begin
        n_fail++; $display("FAIL abandoned_line r=%0d got %0d/%b exp 0/0", r, h_st, h_de);
      end
    end
    for (int r = 0; r < 13; r++) begin
      tick(r < 2, r);
      eh = (r < 8) ? S_PRE : (r < 10) ? S_GUARD : (r < 12) ? S_VIDEO : S_CTRL;
      n_checks++;
      if (h_st !== eh || h_err !== 1'b0) begin
        n_fail++; $display("FAIL restart_line r=%0d got %0d/%b exp %0d/0", r, h_st, h_err, eh);
      end
    end
  endtask

  task automatic test_gap_err;
    logic [1:0] eh, ed;
    idle(12);
    for (int r = 0; r < 25; r++) begin
      tick((r < 4) || (r >= 9 && r < 13), r);
      eh = (r < 8) ? S_PRE : (r < 10) ? S_GUARD : (r < 14) ? S_VIDEO : (r < 19) ? S_CTRL :
           (r < 23) ? S_VIDEO : S_CTRL;
      ed = ((r >= 10 && r < 14) || (r >= 19 && r < 23)) ? S_VIDEO : S_CTRL;
      n_checks++;
      if (h_st !== eh || d_st !== ed) begin
        n_fail++; $display("FAIL gap_state r=%0d got %0d/%0d exp %0d/%0d", r, h_st, d_st, eh, ed);
      end
      n_checks++;
      if (h_err !== (r >= 9) || d_err !== 1'b0) begin
        n_fail++; $display("FAIL gap_err r=%0d got %b/%b exp %b/0", r, h_err, d_err, r >= 9);
      end
      if (r >= 19 && r < 23) begin
        n_checks++;
        if ({h_c0, h_c1, h_c2} !== {wa(r - 10), wb(r - 10), wc(r - 10)}) begin
          n_fail++; $display("FAIL gap_words r=%0d got %h exp %h", r, {h_c0, h_c1, h_c2}, {wa(r - 10), wb(r - 10), wc(r - 10)});
        end
      end
    end
  endtask

  task automatic test_err_sticky;
    idle(12);
    for (int r = 0; r < 16; r++) tick(r < 3, r);
    n_checks++;
    if (h_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", h_err); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (h_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", h_err); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_hdmi_line();
    test_single_pulse();
    test_midline_reset();
    test_gap_err();
    test_err_sticky();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
